// File: rtl/dmix_pkg.sv
// Shared definitions for the audio resampling / FIR datapath.
// Sample width and the tap-sequencer state encoding; no logic.
package dmix_pkg;
  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    POP   = 2'd2,
    FLUSH = 2'd3
  } tap_state_t;
endpackage

// File: rtl/ringbuf_fill_mon.sv
// Ring buffer occupancy estimate plus sticky underrun/overrun/dropped-request flags.
// Latency: all outputs registered, 1 cycle after the causing event; no backpressure.
module ringbuf_fill_mon
  import dmix_pkg::*;
#(
  parameter int LEN      = 16,
  parameter int LEN_LOG2 = 4,
  parameter int NTAPS    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              pop,
  input  logic              accept,
  input  logic              drop,
  input  logic              clr_err,
  output logic [LEN_LOG2:0] fill,
  output logic              underrun,
  output logic              overrun,
  output logic              req_drop
);
  localparam logic [LEN_LOG2:0] FILL_MAX = (LEN_LOG2+1)'(LEN);
  localparam logic [LEN_LOG2:0] FILL_RST = (LEN_LOG2+1)'(LEN / 2);
  localparam logic [LEN_LOG2:0] OVR_TH   = (LEN_LOG2+1)'(LEN - NTAPS);

  // A flag raised in the same cycle as clr_err survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= FILL_RST;
      underrun <= 1'b0;
      overrun  <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      if (we && !pop && fill != FILL_MAX)
        fill <= fill + 1'b1;
      else if (pop && !we && fill != '0)
        fill <= fill - 1'b1;
      underrun <= (accept && fill == '0) | (underrun & ~clr_err);
      overrun  <= (we && fill >= OVR_TH) | (overrun & ~clr_err);
      req_drop <= drop | (req_drop & ~clr_err);
    end
  end
endmodule

// File: rtl/ringbuf_tap_seq.sv
// Ring buffer read sequencer: per request reads NTAPS taps (newest first), emits them tagged, then pops once.
// Latency: tap k valid 2 cycles after its offset, burst NTAPS+2 cycles; requests while busy are dropped, not queued.
module ringbuf_tap_seq
  import dmix_pkg::*;
#(
  parameter int LEN        = 16,
  parameter int LEN_LOG2   = 4,
  parameter int NTAPS      = 4,
  parameter int NTAPS_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic                  req_i,
  output logic                  busy_o,
  output logic                  rb_pop_o,
  output logic [LEN_LOG2-1:0]   rb_offset_o,
  input  logic [SAMPLE_W-1:0]   rb_data_i,
  output logic [SAMPLE_W-1:0]   tap_data_o,
  output logic [NTAPS_LOG2-1:0] tap_idx_o,
  output logic                  tap_valid_o,
  output logic                  tap_last_o,
  output logic [LEN_LOG2:0]     fill_o,
  output logic                  underrun_o,
  output logic                  overrun_o,
  output logic                  req_drop_o,
  input  logic                  clr_err_i
);
  localparam logic [NTAPS_LOG2-1:0] LAST_TAP = NTAPS_LOG2'(NTAPS - 1);

  tap_state_t              state_q, state_d;
  logic [NTAPS_LOG2-1:0]   cnt_q, cnt_d;
  logic                    busy_d, pop_d;
  logic [LEN_LOG2-1:0]     offset_d;
  logic                    rd_vld_q;
  logic [NTAPS_LOG2-1:0]   rd_idx_q;
  logic                    req_q;
  logic                    accept, drop;

  assign accept = (state_q == IDLE) && req_i;
  // Only a fresh request edge counts as dropped, so a held-high req_i streams bursts cleanly.
  assign drop   = (state_q != IDLE) && req_i && !req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (cnt_q == LAST_TAP) state_d = POP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      POP:     state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    busy_d   = (state_d != IDLE);
    pop_d    = (state_d == POP);
    offset_d = (state_d == ISSUE) ? LEN_LOG2'(cnt_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      rb_pop_o    <= 1'b0;
      rb_offset_o <= '0;
    end else begin
      busy_o      <= busy_d;
      rb_pop_o    <= pop_d;
      rb_offset_o <= offset_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      tap_valid_o <= 1'b0;
      tap_last_o  <= 1'b0;
      tap_idx_o   <= '0;
      tap_data_o  <= '0;
    end else begin
      rd_vld_q    <= (state_q == ISSUE);
      rd_idx_q    <= cnt_q;
      tap_valid_o <= rd_vld_q;
      tap_last_o  <= rd_vld_q && (rd_idx_q == LAST_TAP);
      if (rd_vld_q) begin
        tap_idx_o  <= rd_idx_q;
        tap_data_o <= rb_data_i;
      end
    end
  end

  ringbuf_fill_mon #(
    .LEN      (LEN),
    .LEN_LOG2 (LEN_LOG2),
    .NTAPS    (NTAPS)
  ) u_fill_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we_i),
    .pop      (rb_pop_o),
    .accept   (accept),
    .drop     (drop),
    .clr_err  (clr_err_i),
    .fill     (fill_o),
    .underrun (underrun_o),
    .overrun  (overrun_o),
    .req_drop (req_drop_o)
  );
endmodule

// File: tb/tb_ringbuf_tap_seq.sv
// Directed bench for ringbuf_tap_seq with a behavioural 16-deep ring buffer attached.
module tb_ringbuf_tap_seq;
  localparam int LEN = 16, LEN_LOG2 = 4, NTAPS = 4, NTAPS_LOG2 = 2;

  logic clk = 1'b0;
  logic rst_n, we_i, req_i, clr_err_i;
  logic busy_o, rb_pop_o, tap_valid_o, tap_last_o;
  logic underrun_o, overrun_o, req_drop_o;
  logic [LEN_LOG2-1:0]   rb_offset_o;
  logic [23:0]           rb_data_i, tap_data_o, wdat;
  logic [NTAPS_LOG2-1:0] tap_idx_o;
  logic [LEN_LOG2:0]     fill_o;

  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  ringbuf_tap_seq #(.LEN(LEN), .LEN_LOG2(LEN_LOG2), .NTAPS(NTAPS), .NTAPS_LOG2(NTAPS_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .req_i(req_i), .busy_o(busy_o),
    .rb_pop_o(rb_pop_o), .rb_offset_o(rb_offset_o), .rb_data_i(rb_data_i),
    .tap_data_o(tap_data_o), .tap_idx_o(tap_idx_o), .tap_valid_o(tap_valid_o),
    .tap_last_o(tap_last_o), .fill_o(fill_o), .underrun_o(underrun_o),
    .overrun_o(overrun_o), .req_drop_o(req_drop_o), .clr_err_i(clr_err_i)
  );

  // Ring buffer: read head starts LEN/2 behind the write pointer; offset k reads head-k.
  logic [23:0] mem [LEN];
  logic [3:0]  wp, rp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 4'd0;
      rp <= 4'd8;
      rb_data_i <= 24'd0;
      for (int i = 0; i < LEN; i++) mem[i] <= 24'd0;
    end else begin
      if (we_i) begin
        mem[wp] <= wdat;
        wp <= wp + 4'd1;
      end
      if (rb_pop_o) rp <= rp + 4'd1;
      rb_data_i <= mem[4'(rp - rb_offset_o)];
    end
  end

  logic [23:0] cap [NTAPS];
  int cap_n, last_n, last_idx, pop_n;

  // Issues one request at the current negedge and records the burst until busy_o drops.
  task automatic do_burst(input int drop_at, input bit we_on_pop);
    bit seen;
    seen = 1'b0;
    cap_n = 0; last_n = 0; last_idx = -1; pop_n = 0;
    for (int k = 0; k < NTAPS; k++) cap[k] = 24'd0;
    req_i = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      req_i = (cyc == drop_at);
      we_i  = we_on_pop && rb_pop_o;
      wdat  = 24'hABC000 + 24'(cyc);
      if (busy_o) seen = 1'b1;
      else if (seen) break;
      if (tap_valid_o) begin
        cap[tap_idx_o] = tap_data_o;
        cap_n++;
        if (tap_last_o) begin
          last_n++;
          last_idx = int'(tap_idx_o);
        end
      end
      if (rb_pop_o) pop_n++;
    end
    req_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; we_i = 1'b0; req_i = 1'b0; clr_err_i = 1'b0; wdat = 24'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (fill_o !== 5'd8) $display("FAIL reset_fill got %0d exp 8", fill_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else n_pass++;
    n_checks++; if (tap_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", tap_valid_o); else n_pass++;
    n_checks++; if (rb_offset_o !== 4'd0) $display("FAIL reset_offset got %0d exp 0", rb_offset_o); else n_pass++;
    n_checks++; if (rb_pop_o !== 1'b0) $display("FAIL reset_pop got %b exp 0", rb_pop_o); else n_pass++;
    n_checks++; if ({underrun_o, overrun_o, req_drop_o} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {underrun_o, overrun_o, req_drop_o}); else n_pass++;
  endtask

  task automatic test_preload;
    for (int i = 0; i < 16; i++) begin
      we_i = 1'b1;
      wdat = 24'h100 + 24'(i);
      clr_err_i = (i == 15);
      @(negedge clk);
    end
    we_i = 1'b0; clr_err_i = 1'b0;
    n_checks++; if (overrun_o !== 1'b1) $display("FAIL preload_overrun_set_wins got %b exp 1", overrun_o); else n_pass++;
    n_checks++; if (fill_o !== 5'd16) $display("FAIL preload_fill got %0d exp 16", fill_o); else n_pass++;
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    n_checks++; if (overrun_o !== 1'b0) $display("FAIL preload_clr got %b exp 0", overrun_o); else n_pass++;
  endtask

  task automatic test_burst;
    do_burst(0, 1'b0);
    for (int k = 0; k < NTAPS; k++) begin
      n_checks++; if (cap[k] !== 24'h108 - 24'(k))
        $display("FAIL burst1_tap%0d got %h exp %h", k, cap[k], 24'h108 - 24'(k)); else n_pass++;
    end
    n_checks++; if (cap_n !== 4) $display("FAIL burst1_ntaps got %0d exp 4", cap_n); else n_pass++;
    n_checks++; if (last_n !== 1 || last_idx !== 3)
      $display("FAIL burst1_last got n=%0d idx=%0d exp n=1 idx=3", last_n, last_idx); else n_pass++;
    n_checks++; if (pop_n !== 1) $display("FAIL burst1_pops got %0d exp 1", pop_n); else n_pass++;
    n_checks++; if (fill_o !== 5'd15) $display("FAIL burst1_fill got %0d exp 15", fill_o); else n_pass++;
    do_burst(0, 1'b0);
    for (int k = 0; k < NTAPS; k++) begin
      n_checks++; if (cap[k] !== 24'h109 - 24'(k))
        $display("FAIL burst2_tap%0d got %h exp %h", k, cap[k], 24'h109 - 24'(k)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int rises[$];
    int pops;
    bit prev;
    pops = 0;
    prev = busy_o;
    req_i = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (busy_o && !prev) rises.push_back(i);
      prev = busy_o;
      if (rb_pop_o) pops++;
    end
    req_i = 1'b0;
    n_checks++; if (rises.size() !== 3) $display("FAIL b2b_bursts got %0d exp 3", rises.size()); else n_pass++;
    if (rises.size() == 3) begin
      n_checks++; if (rises[1] - rises[0] !== 7 || rises[2] - rises[1] !== 7)
        $display("FAIL b2b_period got %0d,%0d exp 7,7", rises[1] - rises[0], rises[2] - rises[1]); else n_pass++;
    end
    n_checks++; if (pops !== 3) $display("FAIL b2b_pops got %0d exp 3", pops); else n_pass++;
    n_checks++; if (req_drop_o !== 1'b0) $display("FAIL b2b_no_drop got %b exp 0", req_drop_o); else n_pass++;
    n_checks++; if (fill_o !== 5'd11) $display("FAIL b2b_fill got %0d exp 11", fill_o); else n_pass++;
  endtask

  task automatic test_req_drop;
    do_burst(2, 1'b0);
    n_checks++; if (req_drop_o !== 1'b1) $display("FAIL drop_flag got %b exp 1", req_drop_o); else n_pass++;
    for (int k = 0; k < NTAPS; k++) begin
      n_checks++; if (cap[k] !== 24'h10D - 24'(k))
        $display("FAIL drop_tap%0d got %h exp %h", k, cap[k], 24'h10D - 24'(k)); else n_pass++;
    end
    n_checks++; if (pop_n !== 1) $display("FAIL drop_pops got %0d exp 1", pop_n); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL drop_not_queued got busy=%b exp 0", busy_o); else n_pass++;
    n_checks++; if (fill_o !== 5'd10) $display("FAIL drop_fill got %0d exp 10", fill_o); else n_pass++;
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    n_checks++; if (req_drop_o !== 1'b0) $display("FAIL drop_clr got %b exp 0", req_drop_o); else n_pass++;
  endtask

  task automatic test_coincident;
    do_burst(0, 1'b1);
    n_checks++; if (pop_n !== 1) $display("FAIL coinc_pops got %0d exp 1", pop_n); else n_pass++;
    n_checks++; if (fill_o !== 5'd10) $display("FAIL coinc_fill got %0d exp 10", fill_o); else n_pass++;
    n_checks++; if (cap[0] !== 24'h10E) $display("FAIL coinc_tap0 got %h exp 10e", cap[0]); else n_pass++;
  endtask

  task automatic test_underrun;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 8; b++) do_burst(0, 1'b0);
    n_checks++; if (fill_o !== 5'd0) $display("FAIL under_fill8 got %0d exp 0", fill_o); else n_pass++;
    n_checks++; if (underrun_o !== 1'b0) $display("FAIL under_early got %b exp 0", underrun_o); else n_pass++;
    do_burst(0, 1'b0);
    n_checks++; if (underrun_o !== 1'b1) $display("FAIL under_flag got %b exp 1", underrun_o); else n_pass++;
    n_checks++; if (fill_o !== 5'd0) $display("FAIL under_fill9 got %0d exp 0", fill_o); else n_pass++;
    n_checks++; if (pop_n !== 1 || cap_n !== 4)
      $display("FAIL under_runs got pops=%0d taps=%0d exp 1,4", pop_n, cap_n); else n_pass++;
  endtask

  task automatic test_reset_mid_burst;
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (tap_valid_o !== 1'b1) $display("FAIL midrst_pre_valid got %b exp 1", tap_valid_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy_o); else n_pass++;
    n_checks++; if (tap_valid_o !== 1'b0) $display("FAIL midrst_valid got %b exp 0", tap_valid_o); else n_pass++;
    n_checks++; if (rb_pop_o !== 1'b0 || rb_offset_o !== 4'd0)
      $display("FAIL midrst_rb got pop=%b off=%0d exp 0,0", rb_pop_o, rb_offset_o); else n_pass++;
    n_checks++; if (fill_o !== 5'd8) $display("FAIL midrst_fill got %0d exp 8", fill_o); else n_pass++;
    n_checks++; if (underrun_o !== 1'b0) $display("FAIL midrst_flag got %b exp 0", underrun_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_burst();
    test_back_to_back();
    test_req_drop();
    test_coincident();
    test_underrun();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ringbuf_tap_seq.md
Name: ringbuf_tap_seq

Overview:
- Read-side controller for the 24-bit audio sample ring buffer in the resampling/FIR path.
- Per output-sample request it runs a tap burst: presents offsets 0..NTAPS-1, forwards the returned samples as a tagged tap stream to the FIR MAC, then pops the buffer once.
- Also tracks buffer occupancy from the shared write strobe and pop, and flags underrun, overrun and dropped requests.

Parameters:
- LEN, 16, ring buffer depth (must match the buffer instance).
- LEN_LOG2, 4, log2(LEN).
- NTAPS, 4, taps per burst (2 <= NTAPS <= LEN/2).
- NTAPS_LOG2, 2, log2(NTAPS).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- we_i  in  1  sample write strobe; same net as the buffer write enable.
- req_i  in  1  request one tap burst.
- busy_o  out  1  burst in progress.
- rb_pop_o  out  1  drives buffer pop.
- rb_offset_o  out  LEN_LOG2  drives buffer read offset.
- rb_data_i  in  24  buffer read data (1-cycle registered latency from offset).
- tap_data_o  out  24  tap sample.
- tap_idx_o  out  NTAPS_LOG2  tap index, 0 = newest.
- tap_valid_o  out  1  tap_data_o/tap_idx_o valid.
- tap_last_o  out  1  last tap of burst.
- fill_o  out  LEN_LOG2+1  occupancy estimate.
- underrun_o  out  1  sticky.
- overrun_o  out  1  sticky.
- req_drop_o  out  1  sticky.
- clr_err_i  in  1  synchronous clear of all sticky flags.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n, clock clk).
- All outputs are registered. Reset values:
  - busy, pop, tap_valid, tap_last, flags: 0.
  - offset, tap_idx, tap_data: 0.
  - fill_o: LEN/2, matching the buffer's reset read lag.
- FSM: IDLE -> ISSUE -> POP -> FLUSH -> IDLE.
  - IDLE: req_i=1 at an edge -> ISSUE next cycle.
  - ISSUE: lasts NTAPS cycles; rb_offset_o = 0,1,..,NTAPS-1.
  - POP: 1 cycle; rb_pop_o=1, rb_offset_o=0.
  - FLUSH: 1 cycle.
- Burst length is NTAPS+2 cycles. busy_o=1 in every state except IDLE.
- Max request rate: one burst per NTAPS+3 cycles.
- Tap pipeline:
  - Offset presented in cycle t; rb_data_i arrives in t+1; captured into tap_data_o with tap_valid_o=1 and tap_idx_o=k in t+2.
  - Tap k is therefore valid 2 cycles after its offset cycle.
  - The last tap is valid during FLUSH with tap_last_o=1.
  - tap_data_o holds its value when tap_valid_o=0.
- Pop occurs after the last read, so it never affects the taps of the same burst.
- req_i=1 while busy_o=1 is ignored and sets req_drop_o. There is no queueing.
- Fill counter:
  - +1 on we_i, -1 on rb_pop_o; both in the same cycle leaves it unchanged.
  - Saturates at 0 and LEN.
- Underrun: set when a burst is accepted with fill_o==0. The burst still runs (stale data); fill stays 0.
- Overrun: set on we_i when fill_o >= LEN-NTAPS, i.e. the write clobbers the oldest tap window.
- clr_err_i clears the flags. A flag set in the same cycle wins over the clear.
- Reset mid-burst: FSM returns to IDLE immediately and all outputs take reset values. The system resets the buffer in the same window.

Decomposition:
- Shared package dmix_pkg holds SAMPLE_W=24 and the FSM state enum localparams (IDLE/ISSUE/POP/FLUSH).
- One natural sub-module, ringbuf_fill_mon: fill counter, saturation, and the underrun/overrun/req_drop sticky logic with clear.
- The FSM and tap pipeline remain in ringbuf_tap_seq.

Test Plan:
- Reset: after rst_n release -> fill_o=8, all flags/valid/busy=0, rb_offset_o=0.
- Preload with buffer instance (LEN=16, NTAPS=4):
  - Write 16 samples 0x100+i -> overrun_o=1, fill_o=16.
  - clr_err_i -> overrun_o=0.
  - One req_i -> taps idx0..3 = 0x108,0x107,0x106,0x105; tap_last_o on idx3; single rb_pop_o; fill_o=15.
  - Second burst -> taps 0x109..0x106.
- req_i held high -> bursts every 7 cycles, rb_pop_o pulses exactly once per burst, no req_drop_o.
- req_i pulsed 2 cycles into a burst -> ignored, req_drop_o=1, burst output unchanged.
- Underrun: from reset, 8 bursts without writes -> fill_o=0; 9th burst -> underrun_o=1, fill_o stays 0.
- Coincident we_i and rb_pop_o -> fill_o unchanged.
- rst_n low during ISSUE -> busy_o, tap_valid_o, rb_pop_o = 0 immediately; fill_o=8.
